muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It consumes the two register-file read ports (rs, rt) for MULT/MULTU/DIV/DIVU and runs a radix-2 shift-add or restoring-divide sequence. It writes the 64-bit result into HI/LO, which feed the MFHI/MFLO writeback path into the register file. It also services MTHI/MTLO, and its `busy` output drives the pipeline stall for any HI/LO access issued while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/div_restoring_step.sv | 34 +++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the divide-by-zero quotient pattern.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    // Quotient returned on divide by zero; sliced to the operand width.
    localparam logic [63:0] DIV_ZERO_LO = '1;

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restoring_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             fits;

    assign shifted = {remIn, quoIn[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};
    // When the divisor fits the true difference is below 2^WIDTH, so the
    // wrapped WIDTH-bit subtraction is exact.
    assign sub     = shifted[WIDTH-1:0] - divisor;

    always_comb begin
        remOut = shifted[WIDTH-1:0];
        quoOut = {quoIn[WIDTH-2:0], 1'b0};
        if (fits) begin
            remOut = sub;
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiply (divide stays iterative).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] negateIf(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negateWideIf(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_state_t    state;
    logic [CNT_W-1:0] iterCnt;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] accHi, accLo, operand;
    logic             isDivLat, negRes, negRem;

    logic             negA, negB, accept, lastIter;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] divRem, divQuo, nextHi, nextLo, resHi, resLo;
    logic [WIDTH:0]   mulSum;
    logic [2*WIDTH-1:0] prod;

    assign negA     = isSignedOp(op) & opA[WIDTH-1];
    assign negB     = isSignedOp(op) & opB[WIDTH-1];
    assign magA     = negateIf(opA, negA);
    assign magB     = negateIf(opB, negB);
    assign accept   = (state != ST_RUN) && start;
    assign lastIter = iterCnt == CNT_W'(WIDTH - 1);

    div_restoring_step #(.WIDTH(WIDTH)) uStep (
        .remIn  (accHi),
        .quoIn  (accLo),
        .divisor(operand),
        .remOut (divRem),
        .quoOut (divQuo)
    );

    // Shift-add: accHi accumulates the upper product, accLo shifts the multiplier out.
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    assign nextHi = isDivLat ? divRem : mulSum[WIDTH:1];
    assign nextLo = isDivLat ? divQuo : {mulSum[0], accLo[WIDTH-1:1]};

    always_comb begin
        prod  = negateWideIf({nextHi, nextLo}, negRes);
        resHi = prod[2*WIDTH-1:WIDTH];
        resLo = prod[WIDTH-1:0];
        if (isDivLat) begin
            // A zero divisor leaves |opA| in the remainder; restoring its sign yields opA.
            resHi = negateIf(nextHi, negRem);
            resLo = (operand == '0) ? DIV_ZERO_LO[WIDTH-1:0] : negateIf(nextLo, negRes);
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;
    always_comb begin
        if (isSignedOp(op))
            fastProd = $signed({{WIDTH{opA[WIDTH-1]}}, opA}) * $signed({{WIDTH{opB[WIDTH-1]}}, opB});
        else
            fastProd = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
    end
`endif

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            iterCnt <= '0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (lastIter) begin
                        hiReg <= resHi;
                        loReg <= resLo;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) begin
                            {hiReg, loReg} <= fastProd;
                            state          <= ST_DONE;
                        end else begin
                            state   <= ST_RUN;
                            iterCnt <= '0;
                        end
`else
                        state   <= ST_RUN;
                        iterCnt <= '0;
`endif
                    end else begin
                        if (mthi) hiReg <= wdata;
                        if (mtlo) loReg <= wdata;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Datapath operands: loaded on launch, advanced every RUN cycle.
    always_ff @(posedge Clk) begin
        if (accept) begin
            isDivLat <= op[1];
            negRes   <= negA ^ negB;
            negRem   <= negA;
            accHi    <= '0;
            accLo    <= op[1] ? magA : magB;
            operand  <= op[1] ? magB : magA;
        end else if (state == ST_RUN) begin
            accHi <= nextHi;
            accLo <= nextLo;
        end
    end

    assign busy = state == ST_RUN;
    assign done = state == ST_DONE;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default and MULDIV_FAST_MUL_EN builds).
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif

    logic         Clk = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] opA, opB, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; opA = a; opB = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busyCyc);
        cyc = 0; busyCyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busyCyc++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; opA = '0; opB = '0; wdata = '0;
        tick(); tick();
        reset = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    endtask

    task automatic test_moves();
        int cyc, bc;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mt_both_hi: got %h want 12345678", hi); end
        total++; if (lo !== 32'h12345678) begin bad++; $display("FAIL mt_both_lo: got %h want 12345678", lo); end
        mtlo = 1'b1; wdata = 32'h9ABCDEF0;
        tick();
        mtlo = 1'b0;
        total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mtlo_hi: got %h want 12345678", hi); end
        total++; if (lo !== 32'h9ABCDEF0) begin bad++; $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); end
        mtlo = 1'b1; wdata = 32'hDEADBEEF;
        issue(2'b11, 32'd20, 32'd3);
        mtlo = 1'b0;
        total++; if (lo !== 32'h9ABCDEF0) begin bad++; $display("FAIL start_mtlo_drop: got %h want 9abcdef0", lo); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_mtlo_busy: got %b want 1", busy); end
        wait_done(cyc, bc);
        total++; if (cyc !== 32) begin bad++; $display("FAIL divu20_lat: got %0d want 32", cyc); end
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL divu20_lo: got %h want 00000006", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu20_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_multu();
        int cyc, bc;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, bc);
        total++; if (cyc !== MUL_LAT) begin bad++; $display("FAIL multu_lat: got %0d want %0d", cyc, MUL_LAT); end
        total++; if (bc !== MUL_LAT) begin bad++; $display("FAIL multu_busy_cycles: got %0d want %0d", bc, MUL_LAT); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult();
        int cyc, bc;
        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done(cyc, bc);
        total++; if (cyc !== MUL_LAT) begin bad++; $display("FAIL mult_lat: got %0d want %0d", cyc, MUL_LAT); end
        total++; if (bc !== MUL_LAT) begin bad++; $display("FAIL mult_busy_cycles: got %0d want %0d", bc, MUL_LAT); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        tick();
        issue(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD);
        wait_done(cyc, bc);
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL mult_nn_hi: got %h want 00000000", hi); end
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL mult_nn_lo: got %h want 00000006", lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        tick();
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, bc);
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        issue(2'b11, 32'd100, 32'd7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_done(cyc, bc);
        total++; if (cyc !== 32) begin bad++; $display("FAIL b2b_lat: got %0d want 32", cyc); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu100_7_lo: got %h want 0000000e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu100_7_hi: got %h want 00000002", hi); end
        issue(2'b10, 32'd7, 32'hFFFFFFFE);
        wait_done(cyc, bc);
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_pos_neg_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL div_pos_neg_hi: got %h want 00000001", hi); end
    endtask

    task automatic test_div_edges();
        int cyc, bc;
        tick();
        issue(2'b11, 32'd100, 32'd0);
        wait_done(cyc, bc);
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'h00000064) begin bad++; $display("FAIL divu_zero_hi: got %h want 00000064", hi); end
        issue(2'b10, 32'hFFFFFFF9, 32'd0);
        wait_done(cyc, bc);
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_zero_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'hFFFFFFF9) begin bad++; $display("FAIL div_zero_hi: got %h want fffffff9", hi); end
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, bc);
        total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_busy_ignore();
        int cyc, bc;
        tick();
        issue(2'b11, 32'd100, 32'd7);
        repeat (5) tick();
        start = 1'b1; op = 2'b11; opA = 32'd1000; opB = 32'd3;
        mthi = 1'b1; wdata = 32'h12345678;
        tick();
        start = 1'b0; mthi = 1'b0;
        wait_done(cyc, bc);
        total++; if (cyc !== 26) begin bad++; $display("FAIL ignore_lat: got %0d want 26", cyc); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL ignore_lo: got %h want 0000000e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL ignore_hi: got %h want 00000002", hi); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_relaunch: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int doneSeen = 0;
        issue(2'b11, 32'd1000, 32'd3);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL midrst_hi: got %h want 00000000", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL midrst_lo: got %h want 00000000", lo); end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen++;
            tick();
        end
        total++; if (doneSeen !== 0) begin bad++; $display("FAIL midrst_late_done: got %0d want 0", doneSeen); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL midrst_lo_after: got %h want 00000000", lo); end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_multu();
        test_mult();
        test_back_to_back();
        test_div_edges();
        test_busy_ignore();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
